// File: rtl/conv_sigmoid.sv
// 7x7 convolution (Q0.8 pixels x Q8.8 weights) with a fused piecewise-linear sigmoid.
// Fully pipelined: 9 stages to conv_out, 3 more to sig_out, one window per cycle.
module conv_sigmoid (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [391:0] ima,
  input  logic [783:0] wei,
  input  logic [15:0]  bias,
  output logic         conv_valid,
  output logic [15:0]  conv_out,
  output logic         out_valid,
  output logic [15:0]  sig_out
);
  localparam int TAPS = 49;

  logic [11:0]        vld_pipe;
  logic [391:0]       ima_r;
  logic [783:0]       wei_r;
  logic signed [15:0] bias_d [0:7];
  logic signed [31:0] l0 [0:48];
  logic signed [31:0] l1 [0:24];
  logic signed [31:0] l2 [0:12];
  logic signed [31:0] l3 [0:6];
  logic signed [31:0] l4 [0:3];
  logic signed [31:0] l5 [0:1];
  logic signed [31:0] l6;
  logic signed [31:0] acc_sum, acc_shift;
  logic [15:0]        conv_sat, abs_x, mag;
  logic [1:0]         seg_x, seg;
  logic               neg1, neg2;
  logic [8:0]         y_next, y, refl;

  assign conv_valid = vld_pipe[8];
  assign out_valid  = vld_pipe[11];

  always_comb begin
    acc_sum   = l6 + (32'(bias_d[7]) <<< 8);
    acc_shift = acc_sum >>> 8;
    if (acc_shift > 32'sd32767)       conv_sat = 16'h7FFF;
    else if (acc_shift < -32'sd32768) conv_sat = 16'h8000;
    else                              conv_sat = acc_shift[15:0];
  end

  // -32768 has no positive twin, so its magnitude clamps to 32767
  always_comb begin
    abs_x = conv_out[15] ? (16'd0 - conv_out) : conv_out;
    if (conv_out == 16'h8000) abs_x = 16'h7FFF;
    if (abs_x >= 16'd1280)     seg_x = 2'd3;
    else if (abs_x >= 16'd608) seg_x = 2'd2;
    else if (abs_x >= 16'd256) seg_x = 2'd1;
    else                       seg_x = 2'd0;
  end

  always_comb begin
    case (seg)
      2'd3:    y_next = 9'd256;
      2'd2:    y_next = 9'(mag >> 5) + 9'd216;
      2'd1:    y_next = 9'(mag >> 3) + 9'd160;
      default: y_next = 9'(mag >> 2) + 9'd128;
    endcase
    refl = neg2 ? (9'd256 - y) : y;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      vld_pipe <= '0;
      ima_r    <= '0;
      wei_r    <= '0;
      for (int i = 0; i < 8; i++)  bias_d[i] <= '0;
      for (int i = 0; i < 49; i++) l0[i] <= '0;
      for (int i = 0; i < 25; i++) l1[i] <= '0;
      for (int i = 0; i < 13; i++) l2[i] <= '0;
      for (int i = 0; i < 7; i++)  l3[i] <= '0;
      for (int i = 0; i < 4; i++)  l4[i] <= '0;
      for (int i = 0; i < 2; i++)  l5[i] <= '0;
      l6       <= '0;
      conv_out <= '0;
      mag      <= '0;
      seg      <= '0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      y        <= '0;
      sig_out  <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[10:0], enable};
      ima_r     <= ima;
      wei_r     <= wei;
      bias_d[0] <= bias;
      for (int i = 1; i < 8; i++) bias_d[i] <= bias_d[i-1];
      for (int k = 0; k < TAPS; k++)
        l0[k] <= 32'($signed({1'b0, ima_r[k*8 +: 8]})) * 32'($signed(wei_r[k*16 +: 16]));
      // odd leftover of each tree level passes straight through
      for (int i = 0; i < 24; i++) l1[i] <= l0[2*i] + l0[2*i+1];
      l1[24] <= l0[48];
      for (int i = 0; i < 12; i++) l2[i] <= l1[2*i] + l1[2*i+1];
      l2[12] <= l1[24];
      for (int i = 0; i < 6; i++)  l3[i] <= l2[2*i] + l2[2*i+1];
      l3[6]  <= l2[12];
      for (int i = 0; i < 3; i++)  l4[i] <= l3[2*i] + l3[2*i+1];
      l4[3]  <= l3[6];
      for (int i = 0; i < 2; i++)  l5[i] <= l4[2*i] + l4[2*i+1];
      l6     <= l5[0] + l5[1];
      if (vld_pipe[7]) conv_out <= conv_sat;
      neg1 <= conv_out[15];
      mag  <= abs_x;
      seg  <= seg_x;
      neg2 <= neg1;
      y    <= y_next;
      if (vld_pipe[10]) sig_out <= {7'd0, refl};
    end
  end
endmodule

// File: tb/tb_conv_sigmoid.sv
// Bench for conv_sigmoid: cycle-indexed behavioural model plus directed literal checks.
module tb_conv_sigmoid;
  logic         clk = 1'b0;
  logic         rst_n, enable;
  logic [391:0] ima;
  logic [783:0] wei;
  logic [15:0]  bias;
  logic         conv_valid, out_valid;
  logic [15:0]  conv_out, sig_out;

  conv_sigmoid dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ima(ima), .wei(wei), .bias(bias),
    .conv_valid(conv_valid), .conv_out(conv_out), .out_valid(out_valid), .sig_out(sig_out)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int n = 0;
  bit acc_h [0:8191];
  bit rst_h [0:8191];
  int expc  [0:8191];
  int exps  [0:8191];
  int last_c = 0, last_s = 0;
  int nconv = 0, nout = 0;
  int sig_q [$];

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (edge %0d)", nm, got, want, n);
    end
  endtask

  function automatic int conv_model(input logic [391:0] im, input logic [783:0] we, input logic [15:0] bi);
    longint s;
    s = longint'($signed(bi)) * 256;
    for (int k = 0; k < 49; k++)
      s += longint'(im[k*8 +: 8]) * longint'($signed(we[k*16 +: 16]));
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  function automatic int sig_model(input int x);
    int a, yv;
    a = (x < 0) ? -x : x;
    if (a > 32767) a = 32767;
    if (a >= 1280)     yv = 256;
    else if (a >= 608) yv = a / 32 + 216;
    else if (a >= 256) yv = a / 8 + 160;
    else               yv = a / 4 + 128;
    return (x < 0) ? 256 - yv : yv;
  endfunction

  function automatic logic [391:0] rnd_ima();
    logic [391:0] v;
    for (int k = 0; k < 49; k++) v[k*8 +: 8] = 8'($urandom);
    return v;
  endfunction

  function automatic logic [783:0] rnd_wei();
    logic [783:0] v;
    for (int k = 0; k < 49; k++) v[k*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  // Record what the DUT sampled at each rising edge, with the model's answer for it
  initial forever begin
    @(posedge clk);
    if (n < 8190) begin
      n = n + 1;
      rst_h[n] = rst_n;
      acc_h[n] = enable && !rst_n;
      expc[n]  = conv_model(ima, wei, bias);
      exps[n]  = sig_model(expc[n]);
    end
  end

  // Every cycle: valids follow accepted inputs by 9/12 stages unless a reset intervened
  initial forever begin
    @(negedge clk);
    if (n >= 1) begin
      bit ev, es;
      ev = 1'b0;
      es = 1'b0;
      if (n >= 9) begin
        ev = acc_h[n-8];
        for (int j = n - 7; j <= n; j++) if (rst_h[j]) ev = 1'b0;
      end
      if (n >= 12) begin
        es = acc_h[n-11];
        for (int j = n - 10; j <= n; j++) if (rst_h[j]) es = 1'b0;
      end
      if (rst_h[n]) begin last_c = 0; last_s = 0; end
      if (ev) last_c = expc[n-8];
      if (es) last_s = exps[n-11];
      chk("conv_valid", int'(conv_valid), int'(ev));
      chk("out_valid", int'(out_valid), int'(es));
      chk("conv_out", int'($signed(conv_out)), last_c);
      chk("sig_out", int'(sig_out), last_s);
      if (conv_valid) nconv++;
      if (out_valid) begin nout++; sig_q.push_back(int'(sig_out)); end
    end
  end

  task automatic drive(input bit en, input logic [391:0] im, input logic [783:0] we, input logic [15:0] bi);
    @(negedge clk);
    enable = en; ima = im; wei = we; bias = bi;
  endtask

  task automatic pulse_check(input string nm, input logic [391:0] im, input logic [783:0] we,
                             input logic [15:0] bi, input int want_c, input int want_s);
    drive(1'b1, im, we, bi);
    drive(1'b0, rnd_ima(), rnd_wei(), 16'($urandom));
    repeat (8) @(negedge clk);
    chk({nm, "_cv"}, int'(conv_valid), 1);
    chk({nm, "_conv"}, int'($signed(conv_out)), want_c);
    @(negedge clk);
    chk({nm, "_cv_pulse"}, int'(conv_valid), 0);
    repeat (2) @(negedge clk);
    chk({nm, "_ov"}, int'(out_valid), 1);
    chk({nm, "_sig"}, int'(sig_out), want_s);
    @(negedge clk);
    chk({nm, "_ov_pulse"}, int'(out_valid), 0);
    chk({nm, "_conv_hold"}, int'($signed(conv_out)), want_c);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at edge %0d", n);
    $fatal(1, "timeout");
  end

  initial begin
    logic [391:0] all255;
    logic [783:0] w1, wmax, wmin, wr;
    int b0, b1;
    all255 = {49{8'hFF}};
    w1     = {49{16'h0001}};
    wmax   = {49{16'h7FFF}};
    wmin   = {49{16'h8000}};

    chk("pin_conv_bias", conv_model('0, w1, 16'h0100), 256);
    chk("pin_conv_sum", conv_model(all255, w1, 16'h0000), 48);
    chk("pin_conv_satp", conv_model(all255, wmax, 16'h0000), 32767);
    chk("pin_conv_satn", conv_model(all255, wmin, 16'h0000), -32768);
    chk("pin_sig_192", sig_model(256), 192);
    chk("pin_sig_140", sig_model(48), 140);
    chk("pin_sig_64", sig_model(-256), 64);
    chk("pin_sig_0", sig_model(0), 128);
    chk("pin_sig_700", sig_model(700), 237);
    chk("pin_sig_m700", sig_model(-700), 19);
    chk("pin_sig_max", sig_model(32767), 256);
    chk("pin_sig_min", sig_model(-32768), 0);

    // reset with garbage and enable high
    rst_n = 1'b1; enable = 1'b1; ima = rnd_ima(); wei = rnd_wei(); bias = 16'hBEEF;
    repeat (2) @(negedge clk);
    chk("rst_cv", int'(conv_valid), 0);
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_conv", int'(conv_out), 0);
    chk("rst_sig", int'(sig_out), 0);
    rst_n = 1'b0; enable = 1'b0;
    repeat (4) @(negedge clk);

    pulse_check("bias_only", '0, rnd_wei(), 16'h0100, 256, 192);
    pulse_check("sum_trunc", all255, w1, 16'h0000, 48, 140);
    pulse_check("sat_pos", all255, wmax, 16'h0000, 32767, 256);
    pulse_check("sat_neg", all255, wmin, 16'h0000, -32768, 0);
    pulse_check("neg_refl", '0, rnd_wei(), 16'hFF00, -256, 64);

    // streaming, enable pattern 1101...
    b0 = nconv; b1 = nout;
    for (int i = 0; i < 20; i++) begin
      wr = rnd_wei();
      drive((i % 4) != 2, rnd_ima(), wr, 16'($urandom));
    end
    drive(1'b0, '0, '0, '0);
    repeat (14) @(negedge clk);
    chk("stream_conv_cnt", nconv - b0, 15);
    chk("stream_out_cnt", nout - b1, 15);

    // reset in cycle 5 of an 8-cycle burst: only the last 3 inputs survive
    b0 = nconv; b1 = nout;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, rnd_ima(), rnd_wei(), 16'($urandom));
      rst_n = (i == 4);
    end
    drive(1'b0, '0, '0, '0);
    rst_n = 1'b0;
    repeat (14) @(negedge clk);
    chk("midrst_conv_cnt", nconv - b0, 3);
    chk("midrst_out_cnt", nout - b1, 3);

    // sweep conv_out over [-1400,1400] through the bias path
    sig_q.delete();
    for (int x = -1400; x <= 1400; x++) drive(1'b1, '0, rnd_wei(), 16'(x));
    drive(1'b0, '0, '0, '0);
    repeat (14) @(negedge clk);
    chk("sweep_cnt", sig_q.size(), 2801);
    if (sig_q.size() == 2801) begin
      for (int i = 1; i < 2801; i++)
        chk("sweep_mono", int'(sig_q[i] >= sig_q[i-1]), 1);
      for (int i = 0; i <= 1400; i++)
        chk("sweep_sym", sig_q[i] + sig_q[2800-i], 256);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_sigmoid.md
# conv_sigmoid

7×7 convolution core fused with a piecewise-linear sigmoid activation. It takes one 49-pixel window, 49 weights and a bias per enabled cycle and produces one convolution result and its sigmoid per cycle, fully pipelined. It sits in the convolution layer after the line-buffer and window-extraction logic, which supplies windows, weights and bias, and before the pooling/next-layer stage.

## Interface
- No parameters; all widths fixed.
- `clk`  in  1  – single clock, rising edge.
- `rst_n`  in  1  – synchronous, active-high reset, despite the suffix (codebase name kept).
- `enable`  in  1  – `ima`/`wei`/`bias` are valid this cycle.
- `ima`  in  392  – 49 unsigned 8-bit pixels, Q0.8. Tap k = row·7+col at bits [8k+7:8k].
- `wei`  in  784  – 49 signed 16-bit weights, Q8.8. Tap k at bits [16k+15:16k].
- `bias`  in  16  – signed Q8.8.
- `conv_valid`  out  1  – `conv_out` valid.
- `conv_out`  out  16  – signed Q8.8 saturated convolution result.
- `out_valid`  out  1  – `sig_out` valid.
- `sig_out`  out  16  – unsigned Q8.8 sigmoid, range 0..256.

## Operation
- Convolution:
  - For each tap, p_k = ima_k (unsigned) × wei_k (signed), giving 24-bit signed Q8.16.
  - S = Σp_k + (bias <<< 8), carried at ≥31 bits signed with no intermediate overflow.
  - conv = S >>> 8, an arithmetic shift (truncates toward −∞).
  - conv saturates to [−32768, 32767].
- Sigmoid, with x = conv_out and a = |x|; a saturates to 32767 when x = −32768:
  - a ≥ 1280: y = 256.
  - 608 ≤ a < 1280: y = (a>>5) + 216.
  - 256 ≤ a < 608: y = (a>>3) + 160.
  - a < 256: y = (a>>2) + 128.
  - x < 0: sig_out = 256 − y; otherwise sig_out = y. Output is zero-extended to 16 bits.
- Valid bits travel down the pipeline alongside the data. When `enable` is low, that slot is a bubble.
- `conv_out` and `sig_out` hold their last value while the matching valid is low.

## Timing
- Reset: every pipeline register, valid bit and output clears to 0 on the same `clk` edge. In-flight results are discarded and never emerge.
- Convolution pipeline, 9 cycles from the `enable` edge to `conv_valid`:
  - 1: input register.
  - 2: 49 products.
  - 3–8: adder tree, 49→25→13→7→4→2→1.
  - 9: bias add, shift, saturate.
- Sigmoid pipeline, 3 cycles after `conv_valid`:
  - 1: abs and segment select.
  - 2: shift-add.
  - 3: sign reflect.
- Total latency from `enable` to `out_valid` is 12 cycles.
- Throughput is one result per cycle. Input is accepted every cycle; there is no backpressure.
- The valid patterns on `conv_valid` and `out_valid` reproduce the `enable` pattern exactly, delayed by 9 and 12 cycles.
- `enable` asserted in the cycle reset is released is accepted normally.

## Test plan
- Reset: assert `rst_n` for 2 cycles with garbage on the inputs → `conv_valid`=`out_valid`=0 and `conv_out`=`sig_out`=0, held until the first `enable`+9/+12.
- Bias only: pixels 0, `bias`=0x0100, one `enable` pulse → `conv_out`=0x0100 at +9; `sig_out`=0x00C0 (192) at +12; the valids are single-cycle pulses.
- Sum/truncation: all pixels 255, all weights 0x0001, `bias` 0 → `conv_out`=0x0030 (12495>>8=48); `sig_out`=140.
- Saturation:
  - pixels 255, weights 0x7FFF → `conv_out`=0x7FFF, `sig_out`=0x0100.
  - pixels 255, weights 0x8000 → `conv_out`=0x8000, `sig_out`=0x0000.
- Negative reflect: pixels 0, `bias`=0xFF00 → `conv_out`=0xFF00, `sig_out`=64.
  - Also sweep `conv_out` over [−1400, 1400] and check monotonic non-decreasing output with y(x)+y(−x)=256.
- Streaming/reset mid-flight:
  - 20 consecutive distinct windows with `enable` pattern 1101… → outputs in order with matching valid pattern.
  - Reset at cycle 5 of a burst → no outputs from pre-reset inputs.
